// File: rtl/mdu_seq.sv
// mdu_seq: iterative RV32M multiply/divide sequencer for the execute stage.
// One operation at a time: 32 shift-add multiply steps or 32 restoring
// divide steps, one sign/select fix-up cycle, then a one-cycle done pulse.
//
// Handshake: an op is accepted on a rising edge in IDLE when req_valid_i=1
// and flush_i=0. stall_o is high combinationally while the op is present and
// not yet finishing. done_o qualifies result_o for exactly one cycle.
// flush_i overrides everything and returns to IDLE with no done pulse.
module mdu_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  input  logic            flush_i,
  output logic            busy_o,
  output logic            stall_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o,
  output logic [2:0]      state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_e;

  localparam logic [XLEN-1:0] ZERO     = '0;
  localparam logic [XLEN-1:0] ALL_ONES = '1;
  localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  // Multiply: {partial product high, multiplier}; divide: {remainder, quotient}.
  logic [2*XLEN-1:0] acc_q, acc_d;
  // Multiplicand or divisor magnitude.
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic              neg_q, neg_d;
  logic              sel_hi_q, sel_hi_d;
  logic              sel_rem_q, sel_rem_d;
  logic              is_div_q, is_div_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode at acceptance.
  logic              sgn1_en, sgn2_en, s1, s2;
  logic [XLEN-1:0]   mag1, mag2;
  logic              div_zero, div_ovf;
  logic [XLEN-1:0]   fast_res;

  // Datapath helpers.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_sh;
  logic [XLEN:0]     div_diff;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   div_word;
  logic [XLEN-1:0]   fix_res;

  // Signedness, magnitudes and divide special cases for the incoming op.
  always_comb begin
    // rs1 signed for everything except MULHU/DIVU/REMU (funct3 = x11 or 101).
    sgn1_en  = !(funct3_i == 3'b011 || funct3_i == 3'b101 || funct3_i == 3'b111);
    // rs2 signed for MUL, MULH, DIV, REM only.
    sgn2_en  = (funct3_i == 3'b000 || funct3_i == 3'b001 ||
                funct3_i == 3'b100 || funct3_i == 3'b110);
    s1       = sgn1_en & rs1_i[XLEN-1];
    s2       = sgn2_en & rs2_i[XLEN-1];
    mag1     = s1 ? (ZERO - rs1_i) : rs1_i;
    mag2     = s2 ? (ZERO - rs2_i) : rs2_i;
    div_zero = (rs2_i == ZERO);
    div_ovf  = !funct3_i[0] && (rs1_i == MIN_NEG) && (rs2_i == ALL_ONES);
    if (div_zero) fast_res = funct3_i[1] ? rs1_i : ALL_ONES;
    else          fast_res = funct3_i[1] ? ZERO : MIN_NEG;
  end

  // One shift-add or restoring-divide step, and the final sign/select fix-up.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : ZERO)};
    rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    // Remainder stays below the divisor, so a 33-bit difference is exact.
    div_diff = rem_sh - {1'b0, opnd_q};
    prod_fix = neg_q ? ({(2*XLEN){1'b0}} - acc_q) : acc_q;
    div_word = sel_rem_q ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
    if (is_div_q) fix_res = neg_q ? (ZERO - div_word) : div_word;
    else          fix_res = sel_hi_q ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
  end

  // Next-state and datapath updates; flush overrides every state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    sel_hi_d  = sel_hi_q;
    sel_rem_d = sel_rem_q;
    is_div_d  = is_div_q;
    result_d  = result_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && !flush_i) begin
          cnt_d     = 5'd31;
          neg_d     = (funct3_i[2] && funct3_i[1]) ? s1 : (s1 ^ s2);
          sel_hi_d  = (funct3_i[1:0] != 2'b00);
          sel_rem_d = funct3_i[1];
          is_div_d  = funct3_i[2];
          if (!funct3_i[2]) begin
            state_d = S_MUL;
            acc_d   = {ZERO, mag2};
            opnd_d  = mag1;
          end else if (div_zero || div_ovf) begin
            state_d  = S_DONE;
            result_d = fast_res;
          end else begin
            state_d = S_DIV;
            acc_d   = {ZERO, mag1};
            opnd_d  = mag2;
          end
        end
      end
      S_MUL: begin
        acc_d = {mul_sum, acc_q[XLEN-1:1]};
        if (cnt_q == 5'd0) state_d = S_FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_DIV: begin
        if (div_diff[XLEN]) acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
        else                acc_d = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        if (cnt_q == 5'd0) state_d = S_FIX;
        else               cnt_d   = cnt_q - 5'd1;
      end
      S_FIX: begin
        result_d = fix_res;
        state_d  = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= '0;
      opnd_q    <= '0;
      neg_q     <= 1'b0;
      sel_hi_q  <= 1'b0;
      sel_rem_q <= 1'b0;
      is_div_q  <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      neg_q     <= neg_d;
      sel_hi_q  <= sel_hi_d;
      sel_rem_q <= sel_rem_d;
      is_div_q  <= is_div_d;
      result_q  <= result_d;
    end
  end

  assign busy_o   = (state_q != S_IDLE);
  assign stall_o  = req_valid_i && (state_q != S_DONE) && !flush_i;
  assign done_o   = (state_q == S_DONE) && !flush_i;
  assign result_o = result_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: directed checks of mdu_seq results, latency, stall, flush and reset.
module tb_mdu_seq;

  localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010,
                         F_MULHU = 3'b011, F_DIV = 3'b100, F_DIVU = 3'b101,
                         F_REM = 3'b110, F_REMU = 3'b111;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [2:0]  funct3;
  logic [31:0] rs1, rs2;
  logic        flush;
  logic        busy, stall, done;
  logic [31:0] result;
  logic [2:0]  state;

  int n_cmp  = 0;
  int n_fail = 0;

  mdu_seq #(.XLEN(32)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .funct3_i    (funct3),
    .rs1_i       (rs1),
    .rs2_i       (rs2),
    .flush_i     (flush),
    .busy_o      (busy),
    .stall_o     (stall),
    .done_o      (done),
    .result_o    (result),
    .state_o     (state)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: present one op at a negedge (DUT idle), wait for done with a
  // cycle budget. lat is the cycle index of the done pulse (0 = never),
  // stall_cnt counts cycles with stall high. Ends at the negedge of the
  // IDLE cycle following DONE.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output int stall_cnt);
    bit seen;
    req_valid = 1'b1;
    funct3    = f;
    rs1       = a;
    rs2       = b;
    res       = 'x;
    lat       = 0;
    seen      = 1'b0;
    #1;
    stall_cnt = stall ? 1 : 0;
    for (int n = 1; n <= 60 && !seen; n++) begin
      @(negedge clk);
      if (done) begin
        seen      = 1'b1;
        lat       = n;
        res       = result;
        req_valid = 1'b0;
      end else if (stall) begin
        stall_cnt++;
      end
    end
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; funct3 = '0; rs1 = '0; rs2 = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || result !== 32'h0 || state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b stall=%b done=%b result=%h state=%0d, required all 0",
               busy, stall, done, result, state);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mul();
    logic [31:0] r; int lat, st;
    run_op(F_MUL, 32'd7, 32'hFFFF_FFFD, r, lat, st);
    n_cmp++; if (r !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mul_7x-3: got %h required %h", r, 32'hFFFF_FFEB); end
    n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL mul_latency: got %0d required 34", lat); end
    n_cmp++; if (st !== 34) begin n_fail++; $display("FAIL mul_stall_cycles: got %0d required 34", st); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mul_back_to_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_mulh();
    logic [31:0] r; int lat, st;
    run_op(F_MULH, 32'h8000_0000, 32'h8000_0000, r, lat, st);
    n_cmp++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL mulh_min: got %h required %h", r, 32'h4000_0000); end
    run_op(F_MULHU, 32'h8000_0000, 32'h8000_0000, r, lat, st);
    n_cmp++; if (r !== 32'h4000_0000) begin n_fail++; $display("FAIL mulhu_min: got %h required %h", r, 32'h4000_0000); end
    run_op(F_MULHSU, 32'hFFFF_FFFF, 32'd2, r, lat, st);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mulhsu_m1x2: got %h required %h", r, 32'hFFFF_FFFF); end
    run_op(F_MUL, 32'h8000_0000, 32'h8000_0000, r, lat, st);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL mul_min_low: got %h required 0", r); end
    run_op(F_MULHSU, 32'h0000_0003, 32'hFFFF_FFFF, r, lat, st);
    n_cmp++; if (r !== 32'h0000_0002) begin n_fail++; $display("FAIL mulhsu_3xffffffff: got %h required 2", r); end
  endtask

  task automatic test_div();
    logic [31:0] r; int lat, st;
    run_op(F_DIV, 32'hFFFF_FFF9, 32'd2, r, lat, st);
    n_cmp++; if (r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL div_-7/2: got %h required %h", r, 32'hFFFF_FFFD); end
    n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL div_latency: got %0d required 34", lat); end
    run_op(F_REM, 32'hFFFF_FFF9, 32'd2, r, lat, st);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL rem_-7/2: got %h required %h", r, 32'hFFFF_FFFF); end
    n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL rem_latency: got %0d required 34", lat); end
    run_op(F_DIVU, 32'd100, 32'd7, r, lat, st);
    n_cmp++; if (r !== 32'd14) begin n_fail++; $display("FAIL divu_100/7: got %0d required 14", r); end
    n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL divu_latency: got %0d required 34", lat); end
    run_op(F_REMU, 32'd100, 32'd7, r, lat, st);
    n_cmp++; if (r !== 32'd2) begin n_fail++; $display("FAIL remu_100/7: got %0d required 2", r); end
    n_cmp++; if (lat !== 34) begin n_fail++; $display("FAIL remu_latency: got %0d required 34", lat); end
    run_op(F_DIV, 32'd100, 32'hFFFF_FFF9, r, lat, st);
    n_cmp++; if (r !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL div_100/-7: got %h required %h", r, 32'hFFFF_FFF2); end
    run_op(F_DIVU, 32'hFFFF_FFFF, 32'd1, r, lat, st);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_max/1: got %h required %h", r, 32'hFFFF_FFFF); end
  endtask

  task automatic test_div_fast();
    logic [31:0] r; int lat, st;
    run_op(F_DIVU, 32'd5, 32'd0, r, lat, st);
    n_cmp++; if (r !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL divu_by0: got %h required %h", r, 32'hFFFF_FFFF); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL divu_by0_latency: got %0d required 1", lat); end
    n_cmp++; if (st !== 1) begin n_fail++; $display("FAIL divu_by0_stall: got %0d required 1", st); end
    run_op(F_REM, 32'd5, 32'd0, r, lat, st);
    n_cmp++; if (r !== 32'd5) begin n_fail++; $display("FAIL rem_by0: got %h required 5", r); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL rem_by0_latency: got %0d required 1", lat); end
    run_op(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, st);
    n_cmp++; if (r !== 32'h8000_0000) begin n_fail++; $display("FAIL div_ovf: got %h required %h", r, 32'h8000_0000); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL div_ovf_latency: got %0d required 1", lat); end
    run_op(F_REM, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, st);
    n_cmp++; if (r !== 32'h0) begin n_fail++; $display("FAIL rem_ovf: got %h required 0", r); end
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL rem_ovf_latency: got %0d required 1", lat); end
    // Unsigned ops never take the overflow shortcut.
    run_op(F_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, r, lat, st);
    n_cmp++; if (r !== 32'h0 || lat !== 34) begin n_fail++; $display("FAIL divu_no_ovf_path: got %h lat %0d required 0 lat 34", r, lat); end
  endtask

  task automatic test_flush();
    logic [31:0] r; int lat, st;
    req_valid = 1'b1; funct3 = F_DIV; rs1 = 32'd1000; rs2 = 32'd3;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    #1;
    n_cmp++; if (done !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL flush_cycle: done=%b stall=%b required 0 0", done, stall); end
    @(negedge clk);
    flush = 1'b0; req_valid = 1'b0;
    n_cmp++; if (busy !== 1'b0 || state !== 3'd0) begin n_fail++; $display("FAIL flush_to_idle: busy=%b state=%0d required 0 0", busy, state); end
    n_cmp++; if (result !== 32'h0) begin n_fail++; $display("FAIL flush_result_kept: got %h required 0", result); end
    run_op(F_MUL, 32'd3, 32'd4, r, lat, st);
    n_cmp++; if (r !== 32'd12 || lat !== 34) begin n_fail++; $display("FAIL mul_after_flush: got %0d lat %0d required 12 lat 34", r, lat); end
  endtask

  task automatic test_flush_done();
    // Flush coinciding with the fast-path DONE cycle: no pulse, back to IDLE.
    req_valid = 1'b1; funct3 = F_DIVU; rs1 = 32'd9; rs2 = 32'd0;
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b0;
    #1;
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL flush_in_done: done=%b required 0", done); end
    @(negedge clk);
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL flush_in_done_idle: busy=%b required 0", busy); end
  endtask

  task automatic test_async_reset();
    logic [31:0] r; int lat, st;
    req_valid = 1'b1; funct3 = F_MUL; rs1 = 32'd5; rs2 = 32'd6;
    repeat (6) @(negedge clk);
    #2;
    rst_n = 1'b0; req_valid = 1'b0;
    #1;
    n_cmp++;
    if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0 || result !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b stall=%b done=%b result=%h required all 0", busy, stall, done, result);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(F_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r, lat, st);
    n_cmp++; if (r !== 32'hFFFF_FFFE || lat !== 34) begin n_fail++; $display("FAIL mulhu_after_reset: got %h lat %0d required fffffffe lat 34", r, lat); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2; int lat1, lat2, st1, st2;
    run_op(F_DIVU, 32'd1234567, 32'd1000, r1, lat1, st1);
    run_op(F_REMU, 32'd1234567, 32'd1000, r2, lat2, st2);
    n_cmp++; if (r1 !== 32'd1234) begin n_fail++; $display("FAIL b2b_divu: got %0d required 1234", r1); end
    n_cmp++; if (r2 !== 32'd567 || lat2 !== 34 || st2 !== 34) begin n_fail++; $display("FAIL b2b_remu: got %0d lat %0d stall %0d required 567 34 34", r2, lat2, st2); end
  endtask

  initial begin
    test_reset();
    test_flush();
    test_mul();
    test_mulh();
    test_div();
    test_div_fast();
    test_flush_done();
    test_back_to_back();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative multiply/divide sequencer for the RV32M instructions in the execute stage. It accepts one M-extension operation from the execute stage and runs a 32-step shift-add multiply or restoring divide over multiple cycles. It raises `stall` to freeze the pipeline while it runs, then returns the 32-bit result with a one-cycle `done` pulse. It replaces the single-cycle combinational multiply/divide path, which is what sets the critical timing path.

## Interface

- `XLEN`, default 32: operand/result width. Only 32 is supported.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  1: the execute stage holds an M-extension op (`mul_en`).
- `funct3`  in  3: RV32M op. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1`, `rs2`  in  32: operands. Sampled only at acceptance.
- `flush`  in  1: pipeline flush. Aborts any operation in flight.
- `busy`  out  1: the FSM is not in IDLE.
- `stall`  out  1: hold the pipeline front-end and execute stage.
- `done`  out  1: one-cycle pulse; `result` is valid in this cycle.
- `result`  out  32: registered result.

## Operation

**FSM states:** IDLE, MUL, DIV, FIX, DONE.

**IDLE**
- Accept when `req_valid & ~flush`. Latch `funct3`, operand magnitudes, the result-sign flag and the select-high/select-remainder flags.
- Load the step counter with 31.
- Go to MUL if funct3[2]=0, otherwise to DIV.

**Divide fast path (from IDLE)**
- If `rs2`==0, go directly to DONE.
  - DIV/DIVU: `result` = 0xFFFFFFFF.
  - REM/REMU: `result` = `rs1`.
- If DIV/REM is signed with `rs1`=0x80000000 and `rs2`=0xFFFFFFFF, go directly to DONE.
  - DIV: `result` = 0x80000000.
  - REM: `result` = 0.

**Signedness**
- MUL, MULH, DIV, REM: both operands signed.
- MULHSU: `rs1` signed, `rs2` unsigned.
- MULHU, DIVU, REMU: both operands unsigned.
- Magnitudes are taken by two's-complement negation of negative signed operands.
- Product sign = s1 ^ s2.
- Quotient sign = s1 ^ s2.
- Remainder sign = s1 (sign of the dividend).

**MUL (32 cycles)**
- Each cycle: if multiplier LSB = 1, add the multiplicand to the upper half of a 64-bit accumulator.
- Then shift the accumulator right by 1, keeping the carry bit.
- When the counter reaches 0, go to FIX; otherwise decrement.

**DIV (32 cycles)**
- Each cycle: shift {remainder, quotient} left by 1.
- Trial-subtract the divisor from the remainder using a 33-bit subtract.
- If the result is non-negative, keep it and set quotient LSB = 1.
- When the counter reaches 0, go to FIX.

**FIX (1 cycle)**
- Apply sign negation if the sign flag is set.
- Select the low or high product word, or the quotient or remainder.
- Register the value into `result`, then go to DONE.

**DONE (1 cycle)**
- `done`=1; the pipeline advances on this edge.
- Next state is always IDLE. A new request is not accepted in DONE.

**Flush**
- `flush`=1 in any state: next state is IDLE and `done` is not asserted.
- `result` keeps its last value.

**Reset:** state IDLE, counter 0, `result`=0, `done`=0, `busy`=0, `stall`=0.

## Timing

- `busy` = (state != IDLE).
- `stall` = `req_valid` & (state != DONE) & ~`flush`, i.e. combinationally high from the first cycle the op appears in execute.
- Latency is counted from the accepting edge E0 (edge where IDLE samples `req_valid`):
  - Mul/div: 32 iteration edges and 1 FIX edge, so state is DONE after edge E33. `done` is high in cycle 34, and total stall is 34 cycles.
  - Fast-path divide: DONE after E0. `done` is high in cycle 1 and stall is 1 cycle.
- Back-to-back ops: the next op is accepted at the first IDLE edge after DONE, one bubble cycle. `stall` is high during that IDLE cycle.
- `flush` and `done` in the same cycle: the flush wins and the pipeline discards the result. The FSM goes to IDLE either way.
- Asynchronous reset mid-operation: state is IDLE immediately, with no `done` pulse.

## Test plan

- MUL `rs1`=7, `rs2`=0xFFFFFFFD (-3): `result`=0xFFFFFFEB. `done` is high exactly 34 cycles after acceptance and `stall` is high for all 34 cycles.
- MULH and MULHU with both operands 0x80000000:
  - MULH → 0x40000000.
  - MULHU → 0x40000000.
  - MULHSU with `rs1`=0xFFFFFFFF, `rs2`=2 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2. Each pulses `done` at cycle 34.
- Divide by zero and overflow, each with `done` at cycle 1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Flush: assert `flush` in cycle 10 of a DIV. Required: IDLE next cycle, no `done` pulse. A new MUL 3*4 accepted the following cycle returns 12.
- Reset: deassert `rst_n` asynchronously mid-MUL. Required: `busy`, `stall`, `done` and `result` are all 0 immediately. After release, a MULHU 0xFFFFFFFF*0xFFFFFFFF returns 0xFFFFFFFE.
